// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared definitions for the RAM fill/clear/check sequencer.
//   OP_*     : two-bit command encodings carried on the op port.
//   state_e  : sequencer FSM states.
package mem_seq_pkg;

  localparam logic [1:0] OP_FILL  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_CHECK = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    FIN
  } state_e;

endpackage

// File: rtl/mem_seq_checker.sv
// mem_seq_checker: read-back compare and error accumulation for CHECK.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   clear_i      : accepted command strobe, clears accumulated results
//   issue_vld_i  : a read address is being presented to the RAM this cycle
//   issue_addr_i : that read address
//   seed_i       : latched pattern offset
//   rd_data_i    : RAM read data (valid the cycle after the address is issued)
//   error_o      : sticky mismatch flag
//   err_count_o  : number of mismatches
//   err_addr_o   : address of the first mismatch
module mem_seq_checker #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              issue_vld_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              error_o,
  output logic [ADDR_W:0]   err_count_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  logic              pipe_vld_q;
  logic [ADDR_W-1:0] pipe_addr_q;
  logic              error_q, error_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] expected;
  logic              mismatch;

  // The RAM returns data one cycle after the address, so compare against the
  // address held in the delay stage.
  assign expected = DATA_W'(pipe_addr_q) + seed_i;
  assign mismatch = pipe_vld_q && (rd_data_i != expected);

  always_comb begin
    error_d = error_q;
    count_d = count_q;
    addr_d  = addr_q;
    if (clear_i) begin
      error_d = 1'b0;
      count_d = '0;
      addr_d  = '0;
    end else if (mismatch) begin
      error_d = 1'b1;
      count_d = count_q + 1'b1;
      if (!error_q) begin
        addr_d = pipe_addr_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_vld_q  <= 1'b0;
      pipe_addr_q <= '0;
      error_q     <= 1'b0;
      count_q     <= '0;
      addr_q      <= '0;
    end else begin
      pipe_vld_q  <= issue_vld_i;
      pipe_addr_q <= issue_addr_i;
      error_q     <= error_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
    end
  end

  assign error_o     = error_q;
  assign err_count_o = count_q;
  assign err_addr_o  = addr_q;

endmodule

// File: rtl/ram1.sv
// ram1: single-port synchronous RAM, registered address, unregistered output.
//   address : word address, captured on the rising clock edge
//   clock   : clock
//   data    : write data
//   wren    : write enable
//   q       : read data for the address captured on the previous edge
module ram1 #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic [ADDR_W-1:0] address,
  input  logic              clock,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clock) begin
    if (wren) begin
      mem[address] <= data;
    end
    addr_q <= address;
  end

  assign q = mem[addr_q];

endmodule

// File: rtl/mem_sequencer.sv
// mem_sequencer: drives a single-port synchronous RAM to fill it with
// (i + seed), clear it, or read it back and check it against the pattern.
//   clock, reset       : clock, synchronous active-high reset
//   start, op, seed    : command strobe, opcode and pattern offset
//   mem_q              : RAM read data
//   mem_address/data/wren : registered RAM drive
//   busy, done         : command in progress, one-cycle completion pulse
//   error, err_count, err_addr : CHECK results
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              accept;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // FIN is the done cycle and returns to IDLE on its closing edge, so a start
  // seen there is taken exactly as in IDLE (back-to-back commands).
  assign accept = start && ((state_q == IDLE) || (state_q == FIN));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      seed_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      seed_q  <= seed_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    seed_d  = seed_q;
    if (accept) begin
      op_d   = op;
      seed_d = seed;
      cnt_d  = '0;
      case (op)
        OP_FILL, OP_CLEAR: state_d = WRITE;
        OP_CHECK:          state_d = READ;
        default:           state_d = FIN;
      endcase
    end else begin
      case (state_q)
        WRITE: begin
          if (cnt_q == LastAddr) state_d = FIN;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        READ: begin
          if (cnt_q == LastAddr) state_d = DRAIN;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        DRAIN:   state_d = FIN;
        FIN:     state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    wren_d = (state_d == WRITE);
    busy_d = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
    done_d = (state_d == FIN);
    addr_d = ((state_d == WRITE) || (state_d == READ)) ? cnt_d : '0;
    data_d = '0;
    if ((state_d == WRITE) && (op_d == OP_FILL)) begin
      data_d = DATA_W'(cnt_d) + seed_d;
    end
  end

  mem_seq_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_checker (
    .clk_i        (clock),
    .rst_i        (reset),
    .clear_i      (accept),
    .issue_vld_i  (state_q == READ),
    .issue_addr_i (addr_q),
    .seed_i       (seed_q),
    .rd_data_i    (mem_q),
    .error_o      (error),
    .err_count_o  (err_count),
    .err_addr_o   (err_addr)
  );

  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_wren    = wren_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer driving the ram1 model; command results
// are queued when issued and compared when done pulses.
module tb_mem_sequencer;
  import mem_seq_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  typedef struct packed {
    logic          err;
    logic [AW:0]   cnt;
    logic [AW-1:0] addr;
  } res_t;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [1:0]    op;
  logic [DW-1:0] seed, mem_q, mem_data;
  logic [AW-1:0] mem_address, err_addr;
  logic          mem_wren, busy, done, error;
  logic [AW:0]   err_count;

  logic          tb_own, tb_wren;
  logic [AW-1:0] tb_addr;
  logic [DW-1:0] tb_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wren;

  res_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign ram_addr = tb_own ? tb_addr : mem_address;
  assign ram_data = tb_own ? tb_data : mem_data;
  assign ram_wren = tb_own ? tb_wren : mem_wren;

  mem_sequencer #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clock       (clk),
    .reset       (rst),
    .start       (start),
    .op          (op),
    .seed        (seed),
    .mem_q       (mem_q),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_count   (err_count),
    .err_addr    (err_addr)
  );

  ram1 #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) u_ram (
    .address (ram_addr),
    .clock   (clk),
    .data    (ram_data),
    .wren    (ram_wren),
    .q       (mem_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one start; returns in cycle 1 after the sampling edge.
  task automatic issue(input logic [1:0] o, input logic [DW-1:0] s);
    start = 1'b1;
    op    = o;
    seed  = s;
    step();
    start = 1'b0;
    op    = OP_NOP;
    seed  = 8'hA5;
  endtask

  // Waits (bounded) for done, checks latency/activity and the queued result.
  // Returns while still in the done cycle.
  task automatic wait_done(input string tag, input int exp_cyc, input int exp_wren,
                           input int exp_busy);
    int   cyc = 1;
    int   nw = 0;
    int   nb = 0;
    logic seen = 1'b0;
    res_t e;
    while (cyc <= 600) begin
      if (mem_wren) nw++;
      if (busy) nb++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
      cyc++;
    end
    check($sformatf("%s_done_seen", tag), 32'(seen), 32'd1);
    check($sformatf("%s_done_cycle", tag), 32'(cyc), 32'(exp_cyc));
    check($sformatf("%s_wren_cycles", tag), 32'(nw), 32'(exp_wren));
    check($sformatf("%s_busy_cycles", tag), 32'(nb), 32'(exp_busy));
    e = sb_q.pop_front();
    check($sformatf("%s_error", tag), 32'(error), 32'(e.err));
    check($sformatf("%s_err_count", tag), 32'(err_count), 32'(e.cnt));
    check($sformatf("%s_err_addr", tag), 32'(err_addr), 32'(e.addr));
  endtask

  // Counts RAM words in [lo,hi] that differ from the pattern (or from zero).
  task automatic check_ram(input string tag, input int lo, input int hi,
                           input logic [DW-1:0] s, input logic zero);
    int            bad = 0;
    logic [DW-1:0] exp;
    for (int i = lo; i <= hi; i++) begin
      exp = zero ? '0 : DW'(i) + s;
      if (u_ram.mem[AW'(i)] !== exp) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic wait_addr(input string tag, input logic [AW-1:0] a);
    logic ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (mem_wren && (mem_address == a)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int n_done;
    rst     = 1'b1;
    start   = 1'b0;
    op      = OP_NOP;
    seed    = '0;
    tb_own  = 1'b0;
    tb_wren = 1'b0;
    tb_addr = '0;
    tb_data = '0;
    step();
    step();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wren", 32'(mem_wren), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_err_addr", 32'(err_addr), 32'd0);
    rst = 1'b0;
    step();

    // FILL seed 0
    sb_q.push_back('{err: 1'b0, cnt: '0, addr: '0});
    issue(OP_FILL, 8'h00);
    wait_done("fill00", 257, 256, 256);
    step();
    check("fill00_done_single", 32'(done), 32'd0);
    check("fill00_busy_after", 32'(busy), 32'd0);
    check_ram("fill00_ram", 0, 255, 8'h00, 1'b0);

    // FILL seed 0x10 then CHECK seed 0x10 (issued in the done cycle)
    sb_q.push_back('{err: 1'b0, cnt: '0, addr: '0});
    issue(OP_FILL, 8'h10);
    wait_done("fill10", 257, 256, 256);
    check_ram("fill10_ram", 0, 255, 8'h10, 1'b0);
    sb_q.push_back('{err: 1'b0, cnt: '0, addr: '0});
    issue(OP_CHECK, 8'h10);
    wait_done("check10", 258, 0, 257);

    // Seed mismatch: every word differs
    step();
    sb_q.push_back('{err: 1'b0, cnt: '0, addr: '0});
    issue(OP_FILL, 8'h00);
    wait_done("fill_sm", 257, 256, 256);
    sb_q.push_back('{err: 1'b1, cnt: 9'd256, addr: 8'h00});
    issue(OP_CHECK, 8'h01);
    wait_done("check_sm", 258, 0, 257);

    // Single corrupted word
    step();
    sb_q.push_back('{err: 1'b0, cnt: '0, addr: '0});
    issue(OP_FILL, 8'h00);
    wait_done("fill_cw", 257, 256, 256);
    step();
    tb_own  = 1'b1;
    tb_addr = 8'h2A;
    tb_data = 8'hFF;
    tb_wren = 1'b1;
    step();
    tb_wren = 1'b0;
    tb_own  = 1'b0;
    sb_q.push_back('{err: 1'b1, cnt: 9'd1, addr: 8'h2A});
    issue(OP_CHECK, 8'h00);
    wait_done("check_cw", 258, 0, 257);

    // CLEAR
    step();
    sb_q.push_back('{err: 1'b0, cnt: '0, addr: '0});
    issue(OP_CLEAR, 8'h33);
    wait_done("clear", 257, 256, 256);
    check_ram("clear_ram", 0, 255, 8'h00, 1'b1);

    // FILL with an ignored CHECK start and a reset before address 100
    step();
    issue(OP_FILL, 8'h00);
    wait_addr("mid_reach50", 8'd50);
    start = 1'b1;
    op    = OP_CHECK;
    seed  = 8'h55;
    step();
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    check("ign_wren", 32'(mem_wren), 32'd1);
    check("ign_addr", 32'(mem_address), 32'd51);
    check("ign_data", 32'(mem_data), 32'd51);
    wait_addr("mid_reach99", 8'd99);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_wren", 32'(mem_wren), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done) n_done++;
    end
    check("mid_no_done", 32'(n_done), 32'd0);
    check_ram("mid_ram_low", 0, 99, 8'h00, 1'b0);
    check_ram("mid_ram_high", 100, 255, 8'h00, 1'b1);

    // NOP, then a CHECK issued in the NOP done cycle
    sb_q.push_back('{err: 1'b0, cnt: '0, addr: '0});
    issue(OP_NOP, 8'h00);
    wait_done("nop", 1, 0, 0);
    sb_q.push_back('{err: 1'b1, cnt: 9'd156, addr: 8'd100});
    issue(OP_CHECK, 8'h00);
    wait_done("b2b_check", 258, 0, 257);
    step();
    check("b2b_results_hold", 32'(err_count), 32'd156);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
